// File: rtl/arith_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined arithmetic unit among NUM_IN cores, with per-requester credits.
// Define ARB_PROTOCOL_CHECK_EN to enable the sticky o_err protocol checker.
module arith_rr_arbiter #(
    parameter int NUM_IN          = 4,
    parameter int DAT_BITS        = 762,
    parameter int RES_BITS        = 381,
    parameter int CTL_BITS        = 10,
    parameter int OVR_WRT_BIT     = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_IN-1:0]                  i_req_val,
    input  logic [NUM_IN-1:0][DAT_BITS-1:0]    i_req_dat,
    input  logic [NUM_IN-1:0][CTL_BITS-1:0]    i_req_ctl,
    output logic [NUM_IN-1:0]                  o_req_rdy,
    output logic                               o_res_val,
    output logic [DAT_BITS-1:0]                o_res_dat,
    output logic [CTL_BITS-1:0]                o_res_ctl,
    input  logic                               i_res_rdy,
    input  logic                               i_rsp_val,
    input  logic [RES_BITS-1:0]                i_rsp_dat,
    input  logic [CTL_BITS-1:0]                i_rsp_ctl,
    output logic                               o_rsp_rdy,
    output logic [NUM_IN-1:0]                  o_rsp_val,
    output logic [RES_BITS-1:0]                o_rsp_dat,
    output logic [CTL_BITS-1:0]                o_rsp_ctl,
    input  logic [NUM_IN-1:0]                  i_rsp_rdy,
    output logic                               o_err
);

    localparam int IDW = $clog2(NUM_IN);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  CRED_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_IN - 1);
    localparam logic [IDW:0]   NUM_W    = (IDW + 1)'(NUM_IN);

    logic [IDW-1:0]             ptr;
    logic [NUM_IN-1:0][CW-1:0]  credit;
    logic [NUM_IN-1:0]          eligible;
    logic                       load_req;
    logic                       gnt_found;
    logic [IDW-1:0]             gnt_idx;
    logic [IDW:0]               cand_wide;
    logic [IDW-1:0]             cand;
    logic [CTL_BITS-1:0]        gnt_ctl;
    logic [IDW-1:0]             rsp_dest;
    logic [NUM_IN-1:0]          dest_onehot;
    logic [NUM_IN-1:0]          rsp_out_hs;
    logic                       rsp_load;
    logic [CTL_BITS-1:0]        rsp_ctl_clr;

    assign load_req = !o_res_val || i_res_rdy;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = i_req_val[i] && (credit[i] < CRED_MAX);
        end
    end

    // Search upward from ptr, wrapping at NUM_IN, for the first eligible requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand_wide = {1'b0, ptr} + (IDW + 1)'(k);
            if (cand_wide >= NUM_W) begin
                cand_wide = cand_wide - NUM_W;
            end
            cand = cand_wide[IDW-1:0];
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_ctl = i_req_ctl[gnt_idx];
        gnt_ctl[OVR_WRT_BIT +: IDW] = gnt_idx;
        o_req_rdy = '0;
        if (load_req && gnt_found) begin
            o_req_rdy[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_val <= 1'b0;
            ptr       <= '0;
        end else if (load_req) begin
            o_res_val <= gnt_found;
            if (gnt_found) begin
                o_res_dat <= i_req_dat[gnt_idx];
                o_res_ctl <= gnt_ctl;
                ptr       <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // An out-of-range tag decodes to an all-zero one-hot, so such a response is consumed and dropped.
    assign rsp_dest   = i_rsp_ctl[OVR_WRT_BIT +: IDW];
    assign rsp_out_hs = o_rsp_val & i_rsp_rdy;
    assign o_rsp_rdy  = !(|o_rsp_val) || (|rsp_out_hs);
    assign rsp_load   = i_rsp_val && o_rsp_rdy;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            dest_onehot[i] = (rsp_dest == IDW'(i));
        end
        rsp_ctl_clr = i_rsp_ctl;
        rsp_ctl_clr[OVR_WRT_BIT +: IDW] = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_val <= '0;
        end else if (o_rsp_rdy) begin
            o_rsp_val <= rsp_load ? dest_onehot : '0;
            if (rsp_load) begin
                o_rsp_dat <= i_rsp_dat;
                o_rsp_ctl <= rsp_ctl_clr;
            end
        end
    end

    // A grant and a delivered result for the same requester in one cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            credit <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (o_req_rdy[i] && !rsp_out_hs[i] && credit[i] != CRED_MAX) begin
                    credit[i] <= credit[i] + 1'b1;
                end else if (rsp_out_hs[i] && !o_req_rdy[i] && credit[i] != '0) begin
                    credit[i] <= credit[i] - 1'b1;
                end
            end
        end
    end

`ifdef ARB_PROTOCOL_CHECK_EN
    logic              err_q;
    logic [NUM_IN-1:0] zero_credit;
    logic              bad_rsp;
    logic              bad_req;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            zero_credit[i] = (credit[i] == '0);
        end
        bad_rsp = rsp_load && (!(|dest_onehot) || (|(dest_onehot & zero_credit)));
        bad_req = load_req && gnt_found && (i_req_ctl[gnt_idx][OVR_WRT_BIT +: IDW] != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (bad_rsp || bad_req) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
